// File: rtl/ma_row_seq.sv
// Sequential unsigned N x N shift-add multiplier built around one ma_row.
// One multiplier bit is consumed per BUSY cycle; valid/ready on both sides.

module ma_row #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic         y,
  input  logic [N-1:0] si,
  output logic [N:0]   so
);

  logic [N:0]   c;
  logic [N-1:0] pp;

  // Ripple row of full adders: so = si + (x & {N{y}})
  always_comb begin
    pp = x & {N{y}};
    c  = '0;
    so = '0;
    for (int i = 0; i < N; i++) begin
      so[i]  = si[i] ^ pp[i] ^ c[i];
      c[i+1] = (si[i] & pp[i]) | (c[i] & (si[i] ^ pp[i]));
    end
    so[N] = c[N];
  end

endmodule

module ma_row_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  p_lo_q, p_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    so;

  ma_row #(.N(N)) u_row (
    .x  (a_q),
    .y  (b_q[0]),
    .si (acc_q),
    .so (so)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_lo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_lo_q  <= p_lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == CW'(N - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load in IDLE, shift-add in BUSY, hold otherwise
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    p_lo_d = p_lo_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      BUSY: begin
        acc_d  = so[N:1];
        p_lo_d = {so[0], p_lo_q[N-1:1]};
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    p         = {acc_q, p_lo_q};
  end

endmodule

// File: tb/tb_ma_row_seq.sv
// Directed and reference-model bench for ma_row_seq.
// Runs N=4 scenarios plus an N=8 instance for wide-operand checks.

module tb_ma_row_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a, b;
  logic [7:0] p;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ma_row_seq #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p)
  );

  ma_row_seq #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8)
  );

  // Start one op at a negedge, return product and edges to out_valid
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib,
                       output logic [7:0] op, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    lat      = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    op        = p;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [15:0] op, output int lat);
    @(negedge clk);
    in_valid8  = 1'b1;
    a8         = ia;
    b8         = ib;
    out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat       = 0;
    while (!out_valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    op         = p8;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 8'd0) begin
      errors++;
      $display("FAIL reset_in: rdy=%b vld=%b p=%h want 1 0 00",
               in_ready, out_valid, p);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 8'd0) begin
      errors++;
      $display("FAIL reset_out: rdy=%b vld=%b p=%h want 1 0 00",
               in_ready, out_valid, p);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_ready: rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_max();
    logic [7:0] op;
    int lat;
    do_op(4'd15, 4'd15, op, lat);
    checks++;
    if (op !== 8'hE1) begin
      errors++;
      $display("FAIL max_p: got %h want e1", op);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL max_lat: got %0d want 4", lat);
    end
  endtask

  task automatic test_zero();
    logic [7:0] op;
    int lat;
    do_op(4'd0, 4'd9, op, lat);
    checks++;
    if (op !== 8'd0 || lat !== 4) begin
      errors++;
      $display("FAIL zero_a: p=%h lat=%0d want 00 4", op, lat);
    end
    do_op(4'd9, 4'd0, op, lat);
    checks++;
    if (op !== 8'd0 || lat !== 4) begin
      errors++;
      $display("FAIL zero_b: p=%h lat=%0d want 00 4", op, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = 4'd13; b = 4'd11; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = 4'd0; b = 4'd0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== 8'h8F) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b p=%h want 1 0 8f",
                 i, out_valid, in_ready, p);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    logic [7:0] op;
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; a = 4'd7; b = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 8'd0) begin
      errors++;
      $display("FAIL abort_rst: rdy=%b vld=%b p=%h want 1 0 00",
               in_ready, out_valid, p);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1 || p !== 8'd0) begin
      errors++;
      $display("FAIL abort_idle: vld_seen=%b rdy=%b p=%h want 0 1 00",
               seen, in_ready, p);
    end
    do_op(4'd7, 4'd9, op, lat);
    checks++;
    if (op !== 8'd63) begin
      errors++;
      $display("FAIL abort_next: got %0d want 63", op);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [2];
    logic [7:0] prod [2];
    int na, np;
    na = 0; np = 0;
    @(negedge clk);
    in_valid = 1'b1; a = 4'd5; b = 4'd6; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && np < 2; cyc++) begin
      if (in_ready && na < 2) begin
        acc_cyc[na] = cyc;
        na++;
      end
      if (out_valid) begin
        prod[np] = p;
        np++;
      end
      @(negedge clk);
      if (na == 1) begin
        a = 4'd12; b = 4'd3;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (na !== 2 || np !== 2) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d products=%0d want 2 2", na, np);
    end else begin
      checks++;
      if (prod[0] !== 8'd30 || prod[1] !== 8'd36) begin
        errors++;
        $display("FAIL b2b_p: got %0d %0d want 30 36", prod[0], prod[1]);
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 6) begin
        errors++;
        $display("FAIL b2b_gap: got %0d want 6", acc_cyc[1] - acc_cyc[0]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_exhaustive();
    logic [7:0] op;
    logic [7:0] exp;
    int lat;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_op(4'(i), 4'(j), op, lat);
        exp = 8'(i * j);
        checks++;
        if (op !== exp || lat !== 4) begin
          errors++;
          $display("FAIL exh %0d*%0d: p=%0d lat=%0d want %0d 4",
                   i, j, op, lat, exp);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [15:0] op;
    logic [15:0] exp;
    logic [7:0]  ra, rb;
    int lat;
    do_op8(8'd255, 8'd255, op, lat);
    checks++;
    if (op !== 16'd65025 || lat !== 8) begin
      errors++;
      $display("FAIL wide_max: p=%0d lat=%0d want 65025 8", op, lat);
    end
    for (int k = 0; k < 1000; k++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      exp = 16'(ra) * 16'(rb);
      do_op8(ra, rb, op, lat);
      checks++;
      if (op !== exp) begin
        errors++;
        $display("FAIL wide_rand %0d*%0d: got %0d want %0d",
                 ra, rb, op, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_exhaustive();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
